// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and its datapath.
// The controller drives through "master"; the datapath side observes through "slave".
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             branch_ne;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic [3:0]       state;
  logic             trap;
  logic             trap_code;
  logic [CNT_W-1:0] retired;

  modport master (
    input  en, opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           ir_write, regdst, memtoreg, regwrite, alusrca, alusrcb, aluop,
           pcsource, state, trap, trap_code, retired
  );

  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
           ir_write, regdst, memtoreg, regwrite, alusrca, alusrcb, aluop,
           pcsource, state, trap, trap_code, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB controller with step enable, memory timeout,
// sticky trap and retired-instruction counter. Moore controls; strobes only on a firing transition.
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             trap_q, trap_code_q, trap_code_d;
  logic [CNT_W-1:0] retired_q;
  logic [TO_W-1:0]  to_cnt;
  logic             mem_st, fire, to_hit;

  assign mem_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign fire   = bus.en && (!mem_st || bus.mem_ready) && (state_q != S_TRAP);
  // The timeout watches the memory, not the stepper, so en does not gate it.
  assign to_hit = (TIMEOUT != 0) && mem_st && !bus.mem_ready && (to_cnt == TO_LAST);

  always_comb begin
    state_d           = state_q;
    trap_code_d       = trap_code_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.regdst        = 1'b0;
    bus.memtoreg      = 1'b0;
    bus.regwrite      = 1'b0;
    bus.alusrca       = 1'b0;
    bus.alusrcb       = 2'b00;
    bus.aluop         = 2'b00;
    bus.pcsource      = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alusrcb  = 2'b01;
        if (fire) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        if (fire) begin
          case (bus.opcode)
            6'b000000:                               state_d = S_EXEC_R;
            6'b100011, 6'b101011:                    state_d = S_MEM_ADDR;
            6'b000100, 6'b000101:                    state_d = S_BRANCH;
            6'b000010:                               state_d = S_JUMP;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = S_EXEC_I;
            default: begin
              state_d     = S_TRAP;
              trap_code_d = 1'b0;
            end
          endcase
        end
      end
      S_MEM_ADDR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        if (fire) state_d = (op_q == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (fire) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.memtoreg = 1'b1;
        if (fire) begin
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (fire) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        if (fire) state_d = S_R_WB;
      end
      S_R_WB: begin
        bus.regdst = 1'b1;
        if (fire) begin
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_BRANCH: begin
        bus.alusrca   = 1'b1;
        bus.aluop     = 2'b01;
        bus.pcsource  = 2'b01;
        bus.branch_ne = (op_q == 6'b000101);
        if (fire) begin
          bus.pc_write_cond = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_JUMP: begin
        bus.pcsource = 2'b10;
        if (fire) begin
          bus.pc_write = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXEC_I: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = 2'b11;
        if (fire) state_d = S_I_WB;
      end
      S_I_WB: begin
        if (fire) begin
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
      end
      default: ;
    endcase
    if (to_hit) begin
      state_d     = S_TRAP;
      trap_code_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= 1'b0;
      retired_q   <= '0;
      to_cnt      <= '0;
    end else begin
      state_q     <= state_d;
      trap_code_q <= trap_code_d;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (fire && state_q == S_DECODE) op_q <= bus.opcode;
      // Only writeback/branch/jump/store states can fire into FETCH.
      if (fire && state_d == S_FETCH) retired_q <= retired_q + 1'b1;
      if (state_d != state_q) to_cnt <= '0;
      else if (mem_st && !bus.mem_ready) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign bus.state     = state_q;
  assign bus.trap      = trap_q;
  assign bus.trap_code = trap_code_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4) with hand-computed expected states and controls.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   miscmp = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();

  multicycle_ctrl #(.CNT_W(16), .TIMEOUT(4), .TO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.pc_write, bus.ir_write, bus.regwrite, bus.pc_write_cond};
  endfunction

  logic [3:0] cur;
  logic [3:0] step_seq [4];

  initial begin
    step_seq[0] = 4'd1;  step_seq[1] = 4'd10;
    step_seq[2] = 4'd11; step_seq[3] = 4'd0;
    bus.en = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 6'd0;

    // reset
    tick(); tick();
    chk("rst_state", bus.state, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_trap", bus.trap, 0);
    chk("rst_trap_code", bus.trap_code, 0);

    // R-type
    rst = 1'b1; bus.en = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'b000000;
    #1;
    chk("r_fetch_state", bus.state, 0);
    chk("r_fetch_irw_pcw", {bus.ir_write, bus.pc_write, bus.mem_read}, 3'b111);
    tick();
    chk("r_decode", bus.state, 1);
    chk("r_decode_nostrobe", strobes(), 0);
    chk("r_decode_alusrcb", bus.alusrcb, 2'b11);
    tick();
    chk("r_exec", bus.state, 6);
    chk("r_exec_ctl", {bus.alusrca, bus.alusrcb, bus.aluop}, 5'b1_00_10);
    tick();
    chk("r_wb", bus.state, 7);
    chk("r_wb_ctl", {bus.regwrite, bus.regdst, bus.memtoreg}, 3'b110);
    tick();
    chk("r_done", bus.state, 0);
    chk("r_retired", bus.retired, 1);

    // lw with slow memory
    bus.opcode = 6'b100011;
    tick(); tick();
    chk("lw_addr", bus.state, 2);
    chk("lw_addr_ctl", {bus.alusrca, bus.alusrcb}, 3'b1_10);
    bus.mem_ready = 1'b0;
    tick();
    repeat (3) begin
      chk("lw_wait_state", bus.state, 3);
      chk("lw_wait_rd", {bus.mem_read, bus.iord}, 2'b11);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_rd_last", bus.state, 3);
    tick();
    chk("lw_wb", bus.state, 4);
    chk("lw_wb_ctl", {bus.regwrite, bus.memtoreg, bus.regdst}, 3'b110);
    tick();
    chk("lw_retired", bus.retired, 2);

    // sw
    bus.opcode = 6'b101011;
    tick(); tick(); tick();
    chk("sw_state", bus.state, 5);
    chk("sw_ctl", {bus.mem_write, bus.iord, bus.mem_read}, 3'b110);
    tick();
    chk("sw_done", bus.state, 0);
    chk("sw_retired", bus.retired, 3);

    // bne; opcode changed in BRANCH must be ignored
    bus.opcode = 6'b000101;
    tick(); tick();
    bus.opcode = 6'b000000;
    #1;
    chk("bne_state", bus.state, 8);
    chk("bne_ctl", {bus.pc_write_cond, bus.branch_ne, bus.pcsource, bus.aluop}, 6'b1_1_01_01);
    tick();
    chk("bne_retired", bus.retired, 4);

    // j
    bus.opcode = 6'b000010;
    tick(); tick();
    chk("j_state", bus.state, 9);
    chk("j_ctl", {bus.pc_write, bus.pcsource}, 3'b1_10);
    tick();
    chk("j_retired", bus.retired, 5);

    // addi single-stepped: one advance per en pulse
    bus.opcode = 6'b001000;
    bus.en = 1'b0;
    cur = 4'd0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) begin
        #1;
        chk("step_hold", bus.state, cur);
        chk("step_nostrobe", strobes(), 0);
        tick();
      end
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      cur = step_seq[k];
      chk("step_adv", bus.state, cur);
      if (k == 1) chk("addi_ctl", {bus.alusrca, bus.alusrcb, bus.aluop}, 5'b1_10_11);
    end
    chk("step_retired", bus.retired, 6);

    // illegal opcode trap
    bus.en = 1'b1;
    bus.opcode = 6'b111111;
    tick(); tick();
    chk("ill_state", bus.state, 12);
    chk("ill_trap", {bus.trap, bus.trap_code}, 2'b10);
    repeat (20) tick();
    chk("ill_hold", bus.state, 12);
    chk("ill_hold_trap", bus.trap, 1);
    chk("ill_ctl_zero", {strobes(), bus.mem_read, bus.mem_write}, 0);
    chk("ill_retired", bus.retired, 6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rerst_state", bus.state, 0);
    chk("rerst_retired", bus.retired, 0);
    chk("rerst_trap", bus.trap, 0);

    // timeout in FETCH
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b000000;
    repeat (3) begin
      #1;
      chk("to_wait", bus.state, 0);
      tick();
    end
    chk("to_c4", bus.state, 0);
    tick();
    chk("to_state", bus.state, 12);
    chk("to_trap", {bus.trap, bus.trap_code}, 2'b11);

    // mem_ready on the limit cycle wins
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("race_c4", bus.state, 0);
    tick();
    chk("race_state", bus.state, 1);
    chk("race_trap", bus.trap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
